// File: rtl/axi_sram_slave_pkg.sv
// ============================================================================
// Module      : axi_sram_slave_pkg
// Description : Shared AXI response/burst/size codes and the bridge FSM state
//               type used by axi_sram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package axi_sram_slave_pkg;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;
    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [2:0] C_SIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axi_sram_slave.sv
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI4 slave bridge to a single-port word-addressed SRAM with
//               one-cycle read latency. Define SRAM_SLAVE_ERR_CHECK_EN to flag
//               WLAST mismatches and non-word AxSIZE with SLVERR responses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // write address
    input  logic [ID_W-1:0]   AWID_S,
    input  logic [ADDR_W-1:0] AWADDR_S,
    input  logic [LEN_W-1:0]  AWLEN_S,
    input  logic [2:0]        AWSIZE_S,
    input  logic [1:0]        AWBURST_S,
    input  logic              AWVALID_S,
    output logic              AWREADY_S,
    // write data
    input  logic [DATA_W-1:0] WDATA_S,
    input  logic [STRB_W-1:0] WSTRB_S,
    input  logic              WLAST_S,
    input  logic              WVALID_S,
    output logic              WREADY_S,
    // write response
    output logic [ID_W-1:0]   BID_S,
    output logic [1:0]        BRESP_S,
    output logic              BVALID_S,
    input  logic              BREADY_S,
    // read address
    input  logic [ID_W-1:0]   ARID_S,
    input  logic [ADDR_W-1:0] ARADDR_S,
    input  logic [LEN_W-1:0]  ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    // read data
    output logic [ID_W-1:0]   RID_S,
    output logic [DATA_W-1:0] RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,
    // SRAM macro
    output logic              CS,
    output logic              OE,
    output logic [STRB_W-1:0] WEB,
    output logic [MEM_AW-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          burst_q, burst_d;
    logic                last_wr_q, last_wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_first_q, rd_first_d;
    logic                size_err_q, size_err_d;
    logic                wlast_err_q, wlast_err_d;

    logic                w_grant_rd;
    logic                w_grant_wr;
    logic                w_beat_last;
    logic [MEM_AW-1:0]   w_addr_next;
    logic                w_ar_size_bad;
    logic                w_aw_size_bad;
    logic                w_unused_ok;

    // Read wins a tie unless the previous transaction was a read.
    assign w_grant_rd    = ARVALID_S && (!AWVALID_S || last_wr_q);
    assign w_grant_wr    = AWVALID_S && (!ARVALID_S || !last_wr_q);
    assign w_beat_last   = (cnt_q == len_q);
    assign w_addr_next   = (burst_q == C_BURST_FIXED) ? addr_q : addr_q + 1'b1;
    assign w_ar_size_bad = (ARSIZE_S != C_SIZE_WORD);
    assign w_aw_size_bad = (AWSIZE_S != C_SIZE_WORD);

    assign RID_S   = id_q;
    assign BID_S   = id_q;
    // DO is only valid on the first R cycle; afterwards the captured copy holds.
    assign RDATA_S = rd_first_q ? DO : rdata_q;

    assign w_unused_ok = ^{ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0],
                           AWADDR_S[ADDR_W-1:MEM_AW+2], AWADDR_S[1:0]
`ifndef SRAM_SLAVE_ERR_CHECK_EN
                           , WLAST_S, w_ar_size_bad, w_aw_size_bad
`endif
                          };

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
            last_wr_q   <= 1'b1;
            rdata_q     <= '0;
            rd_first_q  <= 1'b0;
            size_err_q  <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            last_wr_q   <= last_wr_d;
            rdata_q     <= rdata_d;
            rd_first_q  <= rd_first_d;
            size_err_q  <= size_err_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        last_wr_d   = last_wr_q;
        rdata_d     = rdata_q;
        rd_first_d  = 1'b0;
        size_err_d  = size_err_q;
        wlast_err_d = wlast_err_q;

        ARREADY_S = 1'b0;
        AWREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        RVALID_S  = 1'b0;
        RLAST_S   = 1'b0;
        RRESP_S   = C_RESP_OKAY;
        BVALID_S  = 1'b0;
        BRESP_S   = C_RESP_OKAY;
        CS        = 1'b0;
        OE        = 1'b0;
        WEB       = '1;
        A         = '0;
        DI        = '0;

        case (state_q)
            ST_IDLE: begin
                ARREADY_S = w_grant_rd;
                AWREADY_S = w_grant_wr;
                if (w_grant_rd) begin
                    id_d    = ARID_S;
                    addr_d  = ARADDR_S[MEM_AW+1:2];
                    len_d   = ARLEN_S;
                    burst_d = ARBURST_S;
                    cnt_d   = '0;
`ifdef SRAM_SLAVE_ERR_CHECK_EN
                    size_err_d = w_ar_size_bad;
`else
                    size_err_d = 1'b0;
`endif
                    state_d = ST_RD_ADDR;
                end else if (w_grant_wr) begin
                    id_d        = AWID_S;
                    addr_d      = AWADDR_S[MEM_AW+1:2];
                    len_d       = AWLEN_S;
                    burst_d     = AWBURST_S;
                    cnt_d       = '0;
                    wlast_err_d = 1'b0;
`ifdef SRAM_SLAVE_ERR_CHECK_EN
                    size_err_d = w_aw_size_bad;
`else
                    size_err_d = 1'b0;
`endif
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_ADDR: begin
                CS         = 1'b1;
                OE         = 1'b1;
                A          = addr_q;
                rd_first_d = 1'b1;
                state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                RVALID_S = 1'b1;
                RLAST_S  = w_beat_last;
                RRESP_S  = size_err_q ? C_RESP_SLVERR : C_RESP_OKAY;
                if (rd_first_q) begin
                    rdata_d = DO;
                end
                if (RREADY_S) begin
                    if (w_beat_last) begin
                        last_wr_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = w_addr_next;
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_DATA: begin
                WREADY_S = 1'b1;
                if (WVALID_S) begin
                    CS  = 1'b1;
                    WEB = ~WSTRB_S;
                    A   = addr_q;
                    DI  = WDATA_S;
`ifdef SRAM_SLAVE_ERR_CHECK_EN
                    wlast_err_d = wlast_err_q | (WLAST_S != w_beat_last);
`endif
                    if (w_beat_last) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = w_addr_next;
                    end
                end
            end
            ST_WR_RESP: begin
                BVALID_S = 1'b1;
                BRESP_S  = (size_err_q || wlast_err_q) ? C_RESP_SLVERR : C_RESP_OKAY;
                if (BREADY_S) begin
                    last_wr_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No handshake or SRAM write may take effect in a reset cycle.
        if (ARESET) begin
            ARREADY_S = 1'b0;
            AWREADY_S = 1'b0;
            WREADY_S  = 1'b0;
            RVALID_S  = 1'b0;
            RLAST_S   = 1'b0;
            RRESP_S   = C_RESP_OKAY;
            BVALID_S  = 1'b0;
            BRESP_S   = C_RESP_OKAY;
            CS        = 1'b0;
            OE        = 1'b0;
            WEB       = '1;
            A         = '0;
            DI        = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Self-checking bench for axi_sram_slave against an SRAM model
//               and an array-based reference memory (SRAM_SLAVE_ERR_CHECK_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_sram_slave;

    localparam int MEM_WORDS = 16384;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  AWID_S = '0;
    logic [31:0] AWADDR_S = '0;
    logic [3:0]  AWLEN_S = '0;
    logic [2:0]  AWSIZE_S = 3'b010;
    logic [1:0]  AWBURST_S = 2'b01;
    logic        AWVALID_S = 1'b0;
    logic        AWREADY_S;
    logic [31:0] WDATA_S = '0;
    logic [3:0]  WSTRB_S = '0;
    logic        WLAST_S = 1'b0;
    logic        WVALID_S = 1'b0;
    logic        WREADY_S;
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S = 1'b0;
    logic [7:0]  ARID_S = '0;
    logic [31:0] ARADDR_S = '0;
    logic [3:0]  ARLEN_S = '0;
    logic [2:0]  ARSIZE_S = 3'b010;
    logic [1:0]  ARBURST_S = 2'b01;
    logic        ARVALID_S = 1'b0;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S = 1'b0;
    logic        CS;
    logic        OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO = '0;

    logic [31:0] sram    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wbuf    [16];
    logic [3:0]  sbuf    [16];
    logic        m_last_wr;
    int          vectors = 0;
    int          miscompares = 0;

    axi_sram_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 ACLK = ~ACLK;

    // Synchronous SRAM macro: read data appears the cycle after the access.
    always @(posedge ACLK) begin
        if (CS && OE) DO <= sram[A];
        if (CS) begin
            for (int k = 0; k < 4; k++) begin
                if (!WEB[k]) sram[A][k*8 +: 8] <= DI[k*8 +: 8];
            end
        end
    end

    function automatic logic [13:0] next_word(input logic [13:0] w, input logic [1:0] burst);
        int nxt;
        nxt = (burst == 2'b00) ? int'(w) : (int'(w) + 1) % MEM_WORDS;
        return nxt[13:0];
    endfunction

    task automatic do_reset();
        ARVALID_S = 1'b0; AWVALID_S = 1'b0; WVALID_S = 1'b0;
        RREADY_S = 1'b0; BREADY_S = 1'b0; WLAST_S = 1'b0;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        m_last_wr = 1'b1;
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [13:0] word, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int stall_beat, input int stall_cyc);
        logic [13:0] w;
        logic [1:0]  er;
        int          n;
        er = 2'b00;
`ifdef SRAM_SLAVE_ERR_CHECK_EN
        if (size != 3'b010) er = 2'b10;
`endif
        ARID_S = id; ARADDR_S = {16'h0, word, 2'b00}; ARLEN_S = len;
        ARBURST_S = burst; ARSIZE_S = size; ARVALID_S = 1'b1; RREADY_S = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY_S && n < 20) begin @(negedge ACLK); n++; end
        vectors++;
        if (ARREADY_S !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_handshake: ARREADY_S=%b required 1", ARREADY_S);
            ARVALID_S = 1'b0;
            return;
        end
        @(posedge ACLK); #1 ARVALID_S = 1'b0;
        w = word;
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge ACLK);
            vectors++;
            if ({RVALID_S, CS, OE, A} !== {1'b0, 1'b1, 1'b1, w}) begin
                miscompares++;
                $display("FAIL rd_access beat %0d: RVALID=%b CS=%b OE=%b A=%h required 0 1 1 %h",
                         b, RVALID_S, CS, OE, A, w);
            end
            @(posedge ACLK); #1;
            @(negedge ACLK);
            vectors++;
            if ({RVALID_S, RDATA_S, RID_S, RLAST_S, RRESP_S} !==
                {1'b1, ref_mem[w], id, (b == int'(len)), er}) begin
                miscompares++;
                $display("FAIL r_beat %0d: V=%b D=%h ID=%h L=%b R=%b required 1 %h %h %b %b",
                         b, RVALID_S, RDATA_S, RID_S, RLAST_S, RRESP_S,
                         ref_mem[w], id, (b == int'(len)), er);
            end
            if (b == stall_beat) begin
                repeat (stall_cyc) begin
                    @(posedge ACLK); #1;
                    @(negedge ACLK);
                    vectors++;
                    if ({RVALID_S, RDATA_S, RLAST_S} !== {1'b1, ref_mem[w], (b == int'(len))}) begin
                        miscompares++;
                        $display("FAIL r_stall beat %0d: V=%b D=%h L=%b required 1 %h %b",
                                 b, RVALID_S, RDATA_S, RLAST_S, ref_mem[w], (b == int'(len)));
                    end
                end
            end
            RREADY_S = 1'b1;
            @(posedge ACLK); #1 RREADY_S = 1'b0;
            w = next_word(w, burst);
        end
        m_last_wr = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] id, input logic [13:0] word, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int bad_last_beat, input int gap_beat);
        logic [13:0] w;
        logic [1:0]  er;
        logic        lastv;
        int          n;
        er = 2'b00;
`ifdef SRAM_SLAVE_ERR_CHECK_EN
        if (size != 3'b010) er = 2'b10;
        if (bad_last_beat >= 0 && bad_last_beat <= int'(len)) er = 2'b10;
`endif
        AWID_S = id; AWADDR_S = {16'h0, word, 2'b00}; AWLEN_S = len;
        AWBURST_S = burst; AWSIZE_S = size; AWVALID_S = 1'b1;
        WVALID_S = 1'b0; BREADY_S = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY_S && n < 20) begin @(negedge ACLK); n++; end
        vectors++;
        if (AWREADY_S !== 1'b1) begin
            miscompares++;
            $display("FAIL aw_handshake: AWREADY_S=%b required 1", AWREADY_S);
            AWVALID_S = 1'b0;
            return;
        end
        @(posedge ACLK); #1 AWVALID_S = 1'b0;
        w = word;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == gap_beat) begin
                WVALID_S = 1'b0;
                @(negedge ACLK);
                vectors++;
                if ({WREADY_S, CS, WEB} !== {1'b1, 1'b0, 4'hF}) begin
                    miscompares++;
                    $display("FAIL w_gap: WREADY=%b CS=%b WEB=%b required 1 0 1111", WREADY_S, CS, WEB);
                end
                @(posedge ACLK); #1;
            end
            lastv = (b == int'(len));
            if (b == bad_last_beat) lastv = !lastv;
            WDATA_S = wbuf[b]; WSTRB_S = sbuf[b]; WLAST_S = lastv; WVALID_S = 1'b1;
            @(negedge ACLK);
            vectors++;
            if ({WREADY_S, CS, OE, WEB, A, DI} !== {1'b1, 1'b1, 1'b0, ~sbuf[b], w, wbuf[b]}) begin
                miscompares++;
                $display("FAIL w_beat %0d: WREADY=%b CS=%b OE=%b WEB=%b A=%h DI=%h required 1 1 0 %b %h %h",
                         b, WREADY_S, CS, OE, WEB, A, DI, ~sbuf[b], w, wbuf[b]);
            end
            for (int k = 0; k < 4; k++) begin
                if (sbuf[b][k]) ref_mem[w][k*8 +: 8] = wbuf[b][k*8 +: 8];
            end
            @(posedge ACLK); #1 WVALID_S = 1'b0; WLAST_S = 1'b0;
            w = next_word(w, burst);
        end
        @(negedge ACLK);
        vectors++;
        if ({BVALID_S, BID_S, BRESP_S, WREADY_S, CS} !== {1'b1, id, er, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL b_resp: BVALID=%b BID=%h BRESP=%b WREADY=%b CS=%b required 1 %h %b 0 0",
                     BVALID_S, BID_S, BRESP_S, WREADY_S, CS, id, er);
        end
        BREADY_S = 1'b1;
        @(posedge ACLK); #1 BREADY_S = 1'b0;
        m_last_wr = 1'b1;
        w = word;
        n = 0;
        for (int b = 0; b <= int'(len); b++) begin
            if (sram[w] !== ref_mem[w]) n++;
            w = next_word(w, burst);
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL w_mem: %0d words differ from reference, required 0", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge ACLK);
        vectors++;
        if ({ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RLAST_S, RDATA_S, RID_S, BID_S,
             RRESP_S, BRESP_S, CS, OE, WEB, A, DI} !==
            {6'b0, 32'h0, 8'h0, 8'h0, 2'b0, 2'b0, 1'b0, 1'b0, 4'hF, 14'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b%b%b v=%b%b l=%b D=%h ids=%h/%h resp=%b/%b CS=%b OE=%b WEB=%b A=%h DI=%h required all zero WEB=1111",
                     ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RLAST_S, RDATA_S, RID_S, BID_S,
                     RRESP_S, BRESP_S, CS, OE, WEB, A, DI);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_single_read();
        sram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        axi_read(8'h12, 14'h0010, 4'd0, 2'b01, 3'b010, -1, 0);
    endtask

    task automatic test_wrap_read();
        axi_read(8'h5A, 14'h3FFE, 4'd3, 2'b01, 3'b010, 1, 3);
    endtask

    task automatic test_write_strobe();
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        axi_write(8'h33, 14'h0002, 4'd0, 2'b01, 3'b010, -1, -1);
        axi_read(8'h34, 14'h0002, 4'd0, 2'b01, 3'b010, -1, 0);
    endtask

    task automatic test_arbitration();
        do_reset();
        AWID_S = 8'h44; AWADDR_S = {16'h0, 14'h0100, 2'b00}; AWLEN_S = 4'd1;
        AWBURST_S = 2'b01; AWSIZE_S = 3'b010; AWVALID_S = 1'b1;
        ARID_S = 8'h21; ARADDR_S = {16'h0, 14'h0020, 2'b00}; ARLEN_S = 4'd1;
        ARBURST_S = 2'b01; ARSIZE_S = 3'b010; ARVALID_S = 1'b1;
        #1;
        vectors++;
        if ({ARREADY_S, AWREADY_S} !== (m_last_wr ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL arb_first: AR/AW ready=%b%b required %b", ARREADY_S, AWREADY_S,
                     (m_last_wr ? 2'b10 : 2'b01));
        end
        axi_read(8'h21, 14'h0020, 4'd1, 2'b01, 3'b010, -1, 0);
        ARVALID_S = 1'b1;
        #1;
        vectors++;
        if ({ARREADY_S, AWREADY_S} !== (m_last_wr ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL arb_second: AR/AW ready=%b%b required %b", ARREADY_S, AWREADY_S,
                     (m_last_wr ? 2'b10 : 2'b01));
        end
        wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'hA5A5_0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(8'h44, 14'h0100, 4'd1, 2'b01, 3'b010, -1, -1);
        #1;
        vectors++;
        if ({ARREADY_S, AWREADY_S} !== 2'b10) begin
            miscompares++;
            $display("FAIL arb_third: AR/AW ready=%b%b required 10", ARREADY_S, AWREADY_S);
        end
        axi_read(8'h21, 14'h0020, 4'd1, 2'b01, 3'b010, -1, 0);
    endtask

    task automatic test_wlast_err();
        wbuf[0] = $urandom; wbuf[1] = $urandom; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(8'h66, 14'h0200, 4'd1, 2'b01, 3'b010, 0, -1);
    endtask

    task automatic test_reset_midburst();
        logic [13:0] w;
        int          n;
        AWID_S = 8'h77; AWADDR_S = {16'h0, 14'h0300, 2'b00}; AWLEN_S = 4'd3;
        AWBURST_S = 2'b01; AWSIZE_S = 3'b010; AWVALID_S = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY_S && n < 20) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1 AWVALID_S = 1'b0;
        w = 14'h0300;
        for (int b = 0; b < 2; b++) begin
            WDATA_S = $urandom; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b1;
            ref_mem[w] = WDATA_S;
            @(posedge ACLK); #1;
            w = next_word(w, 2'b01);
        end
        WDATA_S = ~ref_mem[w]; ARESET = 1'b1;
        @(negedge ACLK);
        vectors++;
        if ({CS, WEB} !== {1'b0, 4'hF}) begin
            miscompares++;
            $display("FAIL reset_cycle_write: CS=%b WEB=%b required 0 1111", CS, WEB);
        end
        @(posedge ACLK); #1 ARESET = 1'b0; WVALID_S = 1'b0;
        m_last_wr = 1'b1;
        @(negedge ACLK);
        vectors++;
        if ({ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RLAST_S, RDATA_S, RID_S, BID_S,
             RRESP_S, BRESP_S, CS, OE, WEB, A, DI} !==
            {6'b0, 32'h0, 8'h0, 8'h0, 2'b0, 2'b0, 1'b0, 1'b0, 4'hF, 14'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_midburst: rdy=%b%b%b v=%b%b ids=%h/%h CS=%b WEB=%b A=%h DI=%h required reset values",
                     ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RID_S, BID_S, CS, WEB, A, DI);
        end
        n = 0;
        repeat (4) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            if (BVALID_S !== 1'b0) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL reset_no_bresp: BVALID seen %0d cycles, required 0", n);
        end
        n = 0;
        for (int i = 16'h0300; i < 16'h0304; i++) if (sram[i] !== ref_mem[i]) n++;
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL reset_mem: %0d words differ from reference, required 0", n);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_random();
        logic [13:0] word;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        for (int t = 0; t < 24; t++) begin
            word  = 14'($urandom);
            len   = 4'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 4) == 0) ? 3'b001 : 3'b010;
            if ($urandom_range(0, 1) == 1) begin
                axi_read(8'($urandom), word, len, burst, size,
                         $urandom_range(0, int'(len)), $urandom_range(0, 3));
            end else begin
                for (int b = 0; b < 16; b++) begin
                    wbuf[b] = $urandom;
                    sbuf[b] = 4'($urandom);
                end
                axi_write(8'($urandom), word, len, burst, size, -1,
                          $urandom_range(0, int'(len) + 2));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        m_last_wr = 1'b1;
        test_reset();
        test_single_read();
        test_wrap_read();
        test_write_strobe();
        test_arbitration();
        test_wlast_err();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave-side bridge between one interconnect slave port and a single-port word-addressed SRAM macro (one-cycle read latency). It is the responder for the CPU-side AXI masters: it accepts AR/AW bursts, runs SRAM read or write cycles, and returns R beats or a B response. One instance sits in front of each of IM and DM.

## Interface
- ID_W, 8: slave-side ID width (master ID plus interconnect tag)
- ADDR_W, 32: AXI address width
- DATA_W, 32: data width; STRB = DATA_W/8
- LEN_W, 4: burst length field width
- MEM_AW, 14: SRAM word-address width
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  write address
- AWVALID_S  in  1; AWREADY_S  out  1
- WDATA_S/WSTRB_S/WLAST_S  in  DATA_W/STRB/1; WVALID_S  in  1; WREADY_S  out  1
- BID_S  out  ID_W; BRESP_S  out  2; BVALID_S  out  1; BREADY_S  in  1
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  read address
- ARVALID_S  in  1; ARREADY_S  out  1
- RID_S/RDATA_S/RRESP_S/RLAST_S  out  ID_W/DATA_W/2/1; RVALID_S  out  1; RREADY_S  in  1
- CS  out  1  SRAM chip select; OE  out  1  read enable
- WEB  out  STRB  active-low byte write enables
- A  out  MEM_AW  SRAM word address; DI  out  DATA_W; DO  in  DATA_W

## Operation
- FSM: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE: ARREADY_S/AWREADY_S asserted only for the granted channel. One valid → that one. Both valid → round-robin: serve opposite of last_wr flag (reset last_wr=1, so read wins first).
- AR handshake: latch ID, word addr = ARADDR_S[MEM_AW+1:2], len, burst; beat count=0; → RD_ADDR.
- RD_ADDR: CS=1, OE=1, A=addr; → RD_DATA.
- RD_DATA: capture DO into RDATA register on entry cycle; RVALID_S=1, RLAST_S=(count==len), RRESP_S=OKAY. Hold all R outputs stable until RREADY_S. On handshake: last → IDLE, last_wr=0; else count+1, address advance, → RD_ADDR.
- AW handshake: latch ID/addr/len/burst; → WR_DATA.
- WR_DATA: WREADY_S=1; each W handshake same-cycle SRAM write: CS=1, WEB=~WSTRB_S, A=addr, DI=WDATA_S. After beat count==len → WR_RESP; else count+1, address advance.
- WR_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S per Configuration; on BREADY_S → IDLE, last_wr=1.
- Address advance: AWBURST/ARBURST 2'b00 (FIXED) holds address; all other codes INCR by one word, wrapping modulo 2^MEM_AW.
- Size field ignored for datapath (always full word).
- Outside SRAM cycles: CS=0, OE=0, WEB=all ones.

## Timing
- Reset values: all READY/VALID 0, RLAST 0, RDATA/RID/BID 0, RRESP/BRESP 0, CS 0, OE 0, WEB all ones, A 0, DI 0; state IDLE, last_wr 1.
- Read latency: AR handshake cycle t → SRAM access t+1 → RVALID_S at t+2. Throughput one beat per 2 cycles, plus RREADY stalls.
- Write: beat written in its W handshake cycle; BVALID_S the cycle after the last beat.
- READY signals are Moore (depend on state/grant only); no combinational VALID→READY path on R/B.
- Reset mid-burst: next cycle IDLE, no further beats/responses; SRAM write in the reset cycle suppressed (WEB all ones).
- WVALID_S low mid-burst: wait in WR_DATA, no SRAM activity.

## Configuration
- SRAM_SLAVE_ERR_CHECK_EN defined: writes track WLAST mismatch (WLAST_S high on non-final beat or low on final beat) → BRESP_S=SLVERR (2'b10); bursts with AxSIZE≠3'b010 → all RRESP_S/BRESP_S SLVERR; burst length always completes as len+1 beats, data still written/read.
- Undefined: WLAST_S and size ignored; RRESP_S/BRESP_S always OKAY.

## Structure
- Shared package: AXI response constants (OKAY/SLVERR), burst codes, FSM state enum; widths from existing AXI defines.
- Single module; no sub-module (R holding register and FSM inline).

## Test plan
- Single read: SRAM word 0x10 = 0xDEADBEEF, AR addr 0x40 len 0 ID 0x12 → RVALID at t+2, RDATA 0xDEADBEEF, RID 0x12, RLAST 1, RRESP 0.
- 4-beat INCR read from word 0x3FFE with RREADY low 3 cycles on beat 1 → data words 0x3FFE,0x3FFF,0x0000,0x0001, RDATA stable during stall, RLAST only on beat 4.
- Write len 0 addr 0x8, WDATA 0x11223344 WSTRB 4'b0101 → WEB 4'b1010 same cycle, next cycle BVALID, BRESP 0.
- AR and AW valid same cycle after reset → read served first, then write; second simultaneous pair → write first.
- With SRAM_SLAVE_ERR_CHECK_EN: len 1 write, WLAST high on beat 0 → both beats written, BRESP 2'b10; without macro → 2'b00.
- ARESET during beat 2 of a 4-beat write → all outputs at reset values next cycle, no B response, WEB all ones.
